// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between the PC register and decode.
// Latches the PC on fetch_start, issues one req/gnt/rvalid transaction and
// captures the returned word into instr/pc_ir. It reports misaligned PCs and
// bus errors as fetch faults. Responses that arrive after a flush are dropped.
// Optional feature macro: FETCH_TIMEOUT_EN (response timeout -> access fault).
module fetch_unit #(
    parameter logic [31:0] RESET_INSTR    = 32'h0000_0013,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] instr,
    output logic [31:0] pc_ir,
    output logic        fetch_done,
    output logic        fetch_fault,
    output logic        fault_cause,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t      state_reg;
    logic [31:0] addr_reg;
    logic [31:0] instr_reg;
    logic [31:0] pc_ir_reg;
    logic        done_reg;
    logic        fault_reg;
    logic        cause_reg;

    // A misaligned start never reaches the bus; it faults straight from IDLE.
    logic mis_start;
    // A response is kept only if no flush arrives with it. In REQ, the grant
    // must arrive in the same cycle as the response.
    logic rsp_take;
    logic wait_timeout;

    assign mis_start = (state_reg == IDLE) && fetch_start && (pc_in[1:0] != 2'b00);
    assign rsp_take  = imem_rvalid && !flush &&
                       ((state_reg == WAIT) || ((state_reg == REQ) && imem_gnt));

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             cnt_hit;

    // The count restarts from zero when the FSM enters WAIT or DRAIN. The
    // timeout fires in the TIMEOUT_CYCLES-th cycle spent there.
    assign cnt_hit      = (cnt_reg == CNT_LAST);
    assign wait_timeout = (state_reg == WAIT) && !imem_rvalid && !flush && cnt_hit;
`else
    assign wait_timeout = 1'b0;
`endif

    // Fetch FSM plus the instruction/fault registers it updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= 32'h0;
            instr_reg <= RESET_INSTR;
            pc_ir_reg <= 32'h0;
            done_reg  <= 1'b0;
            fault_reg <= 1'b0;
            cause_reg <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_reg   <= '0;
`endif
        end else begin
            done_reg  <= 1'b0;
            fault_reg <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_reg   <= cnt_reg + 1'b1;
`endif

            unique case (state_reg)
                IDLE: begin
                    if (fetch_start && (pc_in[1:0] == 2'b00)) begin
                        addr_reg  <= pc_in;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (imem_gnt && imem_rvalid) begin
                        state_reg <= IDLE;
                    end else if (imem_gnt) begin
                        // After the grant, a flush still has a response to absorb.
                        state_reg <= flush ? DRAIN : WAIT;
`ifdef FETCH_TIMEOUT_EN
                        cnt_reg   <= '0;
`endif
                    end else if (flush) begin
                        state_reg <= IDLE;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_reg <= IDLE;
                    end else if (flush || wait_timeout) begin
                        state_reg <= DRAIN;
`ifdef FETCH_TIMEOUT_EN
                        cnt_reg   <= '0;
`endif
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        state_reg <= IDLE;
`ifdef FETCH_TIMEOUT_EN
                    end else if (cnt_hit) begin
                        state_reg <= IDLE;
`endif
                    end
                end
            endcase

            if (mis_start) begin
                done_reg  <= 1'b1;
                fault_reg <= 1'b1;
                cause_reg <= 1'b0;
                instr_reg <= RESET_INSTR;
                pc_ir_reg <= pc_in;
            end else if (rsp_take) begin
                done_reg  <= 1'b1;
                pc_ir_reg <= addr_reg;
                if (imem_err) begin
                    fault_reg <= 1'b1;
                    cause_reg <= 1'b1;
                    instr_reg <= RESET_INSTR;
                end else begin
                    instr_reg <= imem_rdata;
                end
            end else if (wait_timeout) begin
                done_reg  <= 1'b1;
                fault_reg <= 1'b1;
                cause_reg <= 1'b1;
                instr_reg <= RESET_INSTR;
                pc_ir_reg <= addr_reg;
            end
        end
    end

    // The request and busy flags are decoded from the state register alone.
    assign imem_req    = (state_reg == REQ);
    assign imem_addr   = addr_reg;
    assign busy        = (state_reg != IDLE);
    assign instr       = instr_reg;
    assign pc_ir       = pc_ir_reg;
    assign fetch_done  = done_reg;
    assign fetch_fault = fault_reg;
    assign fault_cause = cause_reg;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the program counter register.
- On a start pulse, latches the current PC, issues one request on a req/gnt/rvalid instruction-memory port, and captures the returned word into the instruction register with its PC (`pc_ir`) for decode/execute.
- Detects misaligned PCs and bus errors and reports them as fetch faults to the trap logic.
- Safely discards in-flight responses after a flush caused by a trap or return redirect.

Parameters:
- RESET_INSTR, 32'h0000_0013, value of `instr` after reset and on fault (ADDI x0,x0,0 NOP).
- TIMEOUT_CYCLES, 255, cycles waiting for `imem_rvalid` before an access fault is raised (only used with the optional feature).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- fetch_start  input  1  single-cycle pulse from the control FSM; begin a fetch.
- pc_in  input  32  current PC from the PC register.
- flush  input  1  abort the current fetch (trap/return redirect).
- imem_req  output  1  request valid.
- imem_addr  output  32  word address of the request.
- imem_gnt  input  1  memory accepted the request this cycle.
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  32  instruction word.
- imem_err  input  1  bus error, qualified by `imem_rvalid`.
- instr  output  32  fetched instruction register.
- pc_ir  output  32  PC of `instr`.
- fetch_done  output  1  one-cycle pulse: `instr`/`pc_ir` updated.
- fetch_fault  output  1  one-cycle pulse coincident with `fetch_done` on a fault.
- fault_cause  output  1  0 = instruction address misaligned, 1 = instruction access fault.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous on `rst`):
  - state = IDLE.
  - `instr` = RESET_INSTR; `pc_ir` = 0.
  - `imem_req`, `fetch_done`, `fetch_fault`, `fault_cause`, `busy` = 0.
  - `imem_addr` = 0.
  - A reset mid-transaction drops everything; any later `imem_rvalid` while IDLE is ignored.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE:
  - On `fetch_start` with `pc_in[1:0]` == 0: latch `pc_in` into an internal address register and go to REQ. `imem_req` is asserted from the next cycle.
  - On `fetch_start` with `pc_in[1:0]` != 0: no bus request. Next cycle pulse `fetch_done` = `fetch_fault` = 1 with `fault_cause` = 0, `pc_ir` = `pc_in`, `instr` = RESET_INSTR. Stay in IDLE.
  - `fetch_start` while not IDLE is ignored.
- REQ:
  - `imem_req` = 1 and `imem_addr` = latched address, both held stable until `imem_gnt`.
  - On `imem_gnt`, go to WAIT.
  - If `imem_gnt` and `imem_rvalid` arrive in the same cycle, the response is consumed in that cycle and the FSM goes straight to IDLE with `fetch_done` asserted next cycle.
- WAIT:
  - `imem_req` = 0.
  - On `imem_rvalid` with `imem_err` = 0: `instr` = `imem_rdata`, `pc_ir` = latched address, `fetch_done` pulses next cycle, go to IDLE.
  - On `imem_rvalid` with `imem_err` = 1: `instr` = RESET_INSTR, `pc_ir` = address, `fetch_done` = `fetch_fault` = 1, `fault_cause` = 1, go to IDLE.
- flush:
  - In REQ before grant: drop `imem_req`, go to IDLE.
  - In REQ with `imem_gnt` in the same cycle, or in WAIT without `imem_rvalid`: go to DRAIN.
  - In WAIT coincident with `imem_rvalid`: discard the response, go to IDLE.
  - A flush never produces `fetch_done`, and `instr`/`pc_ir` are unchanged.
- DRAIN:
  - `imem_req` = 0.
  - Wait for `imem_rvalid`, discard the data, go to IDLE.
  - `fetch_start` in DRAIN is ignored (control holds off while `busy` is high).
- Latency: `fetch_start` to `fetch_done` is at least 3 cycles with grant and rvalid in consecutive cycles; at least 2 cycles with same-cycle grant+rvalid.
- Only one outstanding request at any time. `instr`/`pc_ir` change only in the cycle `fetch_done` is pulsed.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entering WAIT or DRAIN and increments each cycle there.
  - In WAIT, on reaching TIMEOUT_CYCLES: `fetch_done` = `fetch_fault` = 1, `fault_cause` = 1, go to DRAIN so a late response is still absorbed.
  - In DRAIN, on reaching TIMEOUT_CYCLES: return to IDLE.
- Undefined: no counter logic; WAIT and DRAIN wait indefinitely.

Test Plan:
- Normal fetch: `pc_in` = 32'h0000_0100, `fetch_start`; `imem_gnt` 1 cycle later; `imem_rvalid` 1 cycle after grant with `imem_rdata` = 32'h0050_0093 -> `imem_addr` = 0x100; `fetch_done` pulse; `instr` = 0x00500093; `pc_ir` = 0x100; `fetch_fault` = 0.
- Misaligned: `pc_in` = 32'h0000_0102, `fetch_start` -> `imem_req` never asserted; next cycle `fetch_fault` = 1, `fault_cause` = 0, `pc_ir` = 0x102, `instr` = 0x00000013.
- Bus error: `pc_in` = 0x200, response with `imem_err` = 1 -> `fetch_fault` = 1, `fault_cause` = 1, `instr` = 0x00000013.
- Grant stall and flush: hold `imem_gnt` = 0 for 5 cycles -> `imem_addr`/`imem_req` stable throughout; then `flush` in WAIT, response arrives 3 cycles later with 0xDEADBEEF -> no `fetch_done`, `instr` unchanged, `busy` drops the cycle after that response.
- Reset mid-WAIT: assert `rst` 1 cycle -> all outputs at reset values; stale `imem_rvalid` the following cycle ignored; a new fetch of 0x0 completes normally.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES = 4: no `imem_rvalid` after grant -> fault with `fault_cause` = 1 at the 4th WAIT cycle; state goes to DRAIN; a late `imem_rvalid` is absorbed and IDLE is reached.
